// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA timing sequencer.
// Coordinates are COORD_W bits wide, so each axis total must fit in 1024.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;

    typedef enum logic [1:0] {
        PH_ACT,
        PH_FP,
        PH_SYNC,
        PH_BP
    } axis_phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active/porch/sync phase FSM.
// Latency: count updates on the advance clk; phase_nxt_o/wrap_o are combinational look-aheads.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance_i,
    output logic [COORD_W-1:0] count_o,
    output axis_phase_e        phase_nxt_o,
    output logic               wrap_o
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] B_FP    = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] B_SYNC  = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] B_BP    = COORD_W'(ACTIVE + FP + SYNC);

    logic [COORD_W-1:0] count_q, count_d;
    axis_phase_e        phase_q, phase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= LAST;
            phase_q <= PH_BP;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    // Phase transitions are keyed on the value the counter is about to take.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        wrap_o  = advance_i && (count_q == LAST);
        if (advance_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
            case (phase_q)
                PH_ACT:  if (count_d == B_FP)   phase_d = PH_FP;
                PH_FP:   if (count_d == B_SYNC) phase_d = PH_SYNC;
                PH_SYNC: if (count_d == B_BP)   phase_d = PH_BP;
                default: if (count_d == '0)     phase_d = PH_ACT;
            endcase
        end
    end

    assign count_o     = count_q;
    assign phase_nxt_o = phase_d;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: pixel divider, x/y counters, syncs, display enable and line/frame strobes.
// Zero latency between counters and decodes; enable_i=0 freezes everything and zeroes the strobes.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    output logic               pix_tick_o,
    output logic [COORD_W-1:0] xcounter_o,
    output logic [COORD_W-1:0] ycounter_o,
    output logic [COORD_W-1:0] max_x_o,
    output logic [COORD_W-1:0] max_y_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               display_en_o,
    output logic               line_start_o,
    output logic               frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_ctrl: axis total exceeds 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_ctrl: CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic             h_wrap, v_wrap;
    axis_phase_e      h_phase_nxt, v_phase_nxt;
    logic             pix_tick_q, hsync_q, vsync_q, display_en_q;
    logic             line_start_q, frame_start_q;

    assign tick = enable_i && (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q;
        if (enable_i) div_d = tick ? '0 : div_q + 1'b1;
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
    ) u_h_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance_i   (tick),
        .count_o     (xcounter_o),
        .phase_nxt_o (h_phase_nxt),
        .wrap_o      (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
    ) u_v_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance_i   (tick && h_wrap),
        .count_o     (ycounter_o),
        .phase_nxt_o (v_phase_nxt),
        .wrap_o      (v_wrap)
    );

    // Decodes use the axes' next phase so they land in the same clk as the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            hsync_q       <= !SYNC_POL;
            vsync_q       <= !SYNC_POL;
            display_en_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= tick;
            hsync_q       <= (h_phase_nxt == PH_SYNC) ? SYNC_POL : !SYNC_POL;
            vsync_q       <= (v_phase_nxt == PH_SYNC) ? SYNC_POL : !SYNC_POL;
            display_en_q  <= (h_phase_nxt == PH_ACT) && (v_phase_nxt == PH_ACT);
            line_start_q  <= tick && h_wrap;
            frame_start_q <= tick && h_wrap && v_wrap;
        end
    end

    assign pix_tick_o    = pix_tick_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign display_en_o  = display_en_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign max_x_o       = COORD_W'(H_ACTIVE);
    assign max_y_o       = COORD_W'(V_ACTIVE);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two small-timing instances (CLK_DIV=2 active-low, CLK_DIV=1 active-high)
// checked every clk against a model that derives position from the count of enabled clks.
module tb_vga_timing_ctrl;

    localparam int HA = 10, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    logic       a_tick, a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0] a_x, a_y, a_mx, a_my;
    logic       b_tick, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0] b_x, b_y, b_mx, b_my;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .pix_tick_o(a_tick), .xcounter_o(a_x), .ycounter_o(a_y),
        .max_x_o(a_mx), .max_y_o(a_my), .hsync_o(a_hs), .vsync_o(a_vs),
        .display_en_o(a_de), .line_start_o(a_ls), .frame_start_o(a_fs)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .pix_tick_o(b_tick), .xcounter_o(b_x), .ycounter_o(b_y),
        .max_x_o(b_mx), .max_y_o(b_my), .hsync_o(b_hs), .vsync_o(b_vs),
        .display_en_o(b_de), .line_start_o(b_ls), .frame_start_o(b_fs)
    );

    int total = 0;
    int bad   = 0;
    int ec_a  = 0;
    int ec_b  = 0;
    bit tk_a  = 1'b0;
    bit tk_b  = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs follow from how many pixel ticks have elapsed since the parked reset position.
    task automatic check_dut(input string name, input int ec, input bit tk, input int div, input bit pol,
                             input logic tick, input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] mx, input logic [9:0] my,
                             input logic hs, input logic vs, input logic de,
                             input logic ls, input logic fs);
        int p, ex, ey;
        p  = (FT - 1 + ec / div) % FT;
        ex = p % HT;
        ey = p / HT;
        check_val({name, ".pix_tick"}, int'(tick), int'(tk));
        check_val({name, ".x"}, int'(x), ex);
        check_val({name, ".y"}, int'(y), ey);
        check_val({name, ".max_x"}, int'(mx), HA);
        check_val({name, ".max_y"}, int'(my), VA);
        check_val({name, ".hsync"}, int'(hs),
                  int'((ex >= HA + HF && ex < HA + HF + HS) ? pol : !pol));
        check_val({name, ".vsync"}, int'(vs),
                  int'((ey >= VA + VF && ey < VA + VF + VS) ? pol : !pol));
        check_val({name, ".display_en"}, int'(de), int'(ex < HA && ey < VA));
        check_val({name, ".line_start"}, int'(ls), int'(tk && ex == 0));
        check_val({name, ".frame_start"}, int'(fs), int'(tk && p == 0));
    endtask

    task automatic check_all();
        check_dut("a", ec_a, tk_a, 2, 1'b0, a_tick, a_x, a_y, a_mx, a_my, a_hs, a_vs, a_de, a_ls, a_fs);
        check_dut("b", ec_b, tk_b, 1, 1'b1, b_tick, b_x, b_y, b_mx, b_my, b_hs, b_vs, b_de, b_ls, b_fs);
    endtask

    // Called at a negedge: drive enable, take one posedge, update the model, check at the next negedge.
    task automatic step(input logic en);
        enable = en;
        @(posedge clk);
        if (rst_n && en) begin
            ec_a++;
            ec_b++;
            tk_a = (ec_a % 2 == 0);
            tk_b = 1'b1;
        end else begin
            tk_a = 1'b0;
            tk_b = 1'b0;
            if (!rst_n) begin
                ec_a = 0;
                ec_b = 0;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1);
        rst_n = 1'b1;

        // Three full frames free-running, including the corner wrap and first-tick latency.
        for (int i = 0; i < 3 * FT * 2 + 5; i++) step(1'b1);

        for (int i = 0; i < 37; i++) step(1'b0);
        for (int i = 0; i < 50; i++) step(1'b1);

        for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0);

        // Asynchronous reset landing between clock edges.
        for (int i = 0; i < 7; i++) step(1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        ec_a = 0;
        ec_b = 0;
        tk_a = 1'b0;
        tk_b = 1'b0;
        check_all();
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < FT * 2 + 20; i++) step(1'b1);
        for (int i = 0; i < 400; i++) step($urandom_range(0, 1) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
